hfosc_sched: RTL and testbench
==============================

HFOSC_SCHED -- requirements
Module: hfosc_sched

Purpose: sequences the high-frequency oscillator and the glitch-free clock mux select on behalf of several requesters. It runs entirely in the low-frequency clock domain.

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 1..8.
REQ-002 Parameter WAKE_CYC, default 8: clk cycles that hf_en is held before clk_sel rises (oscillator startup); legal range 1..255.
REQ-003 Parameter SETTLE_CYC, default 4: clk cycles allowed for the mux to complete a switch in either direction; legal range 1..255.
REQ-004 Parameter IDLE_CYC, default 16: clk cycles with no request in ON before leaving high-frequency mode; legal range 1..255.
REQ-005 Port clk, input, 1: low-frequency oscillator clock; the only clock of the block.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, NREQ: per-requester demand for the high-frequency clock; level-sensitive.
REQ-008 Port hf_en, output, 1: oscillator enable (HFOSC CLKHFEN).
REQ-009 Port clk_sel, output, 1: glitch-free mux select; 1 selects the high-frequency clock.
REQ-010 Port hf_ready, output, 1: the high-frequency clock is selected and stable.
REQ-011 Port gnt, output, NREQ: gnt[i] = req[i] & hf_ready (combinational).
REQ-012 Port hf_cycles, output, 16: count of clk cycles with hf_en high (see Configuration).

Function
REQ-013 The FSM SHALL have five states: OFF, WAKE, SWITCH, ON and DRAIN; all outputs except gnt are decoded from registered state (Moore).
REQ-014 Output decode per state SHALL be:
- OFF: hf_en=0, clk_sel=0, hf_ready=0.
- WAKE: hf_en=1, clk_sel=0, hf_ready=0.
- SWITCH: hf_en=1, clk_sel=1, hf_ready=0.
- ON: hf_en=1, clk_sel=1, hf_ready=1.
- DRAIN: hf_en=1, clk_sel=0, hf_ready=0.
REQ-015 OFF -> WAKE SHALL occur when |req is sampled high; the phase counter loads WAKE_CYC-1.
REQ-016 In WAKE, SWITCH and DRAIN, the phase counter SHALL decrement every cycle, and the state SHALL exit when the counter equals 0. Each of these states therefore lasts exactly its parameter value in cycles.
REQ-017 WAKE SHALL exit to SWITCH and load SETTLE_CYC-1.
REQ-018 SWITCH SHALL exit to ON and load IDLE_CYC-1 into the idle counter.
REQ-019 In ON, the idle counter SHALL reload IDLE_CYC-1 on any cycle with |req=1 and decrement otherwise. ON -> DRAIN SHALL occur when the counter is 0 and |req=0; the phase counter then loads SETTLE_CYC-1.
REQ-020 DRAIN exit SHALL depend on |req in the exit cycle:
- |req=1: go to SWITCH (the oscillator is still running, so no WAKE) and load SETTLE_CYC-1.
- |req=0: go to OFF.
REQ-021 A request dropping during WAKE or SWITCH SHALL NOT abort the sequence; the FSM still reaches ON and then times out per REQ-019.
REQ-022 Latency: with req first sampled high in OFF at cycle 0, the outputs SHALL respond as follows:
- hf_en is high from cycle 1.
- clk_sel is high from cycle 1+WAKE_CYC.
- hf_ready is high from cycle 1+WAKE_CYC+SETTLE_CYC.
REQ-023 clk_sel SHALL only change while hf_en is high, and hf_en SHALL fall only in the cycle after clk_sel has been low for SETTLE_CYC cycles.
REQ-024 Counter widths SHALL be 8 bits; there is no wrap-around because counters are always reloaded before use.

Reset
REQ-025 While reset=1 at a clk edge, the state SHALL become OFF, all counters 0, and hf_en=clk_sel=hf_ready=0. gnt then reads all zeros.
REQ-026 Reset asserted in any state, including mid-WAKE or mid-DRAIN, SHALL take effect at the next edge with no drain sequence. The system reset owner guarantees the mux is also held in reset.
REQ-027 hf_cycles SHALL reset to 0.

Configuration
REQ-028 Macro HFOSC_STATS_EN:
- Defined: hf_cycles increments on every cycle with hf_en=1 and saturates at 16'hFFFF.
- Undefined: hf_cycles is constant 0 and the counter logic is absent.

Verification
REQ-029 Defaults, req=4'b0001 pulsed for 1 cycle at cycle 0: hf_en rises at cycle 1, clk_sel at 9, hf_ready at 13; DRAIN at 29; clk_sel falls at 29, hf_en falls at 33; state OFF.
REQ-030 req[2] held high continuously: hf_ready and gnt[2] stay high indefinitely; gnt[0], gnt[1] and gnt[3] stay 0; no DRAIN entry.
REQ-031 req re-asserted during the 2nd DRAIN cycle: DRAIN completes (4 cycles), then SWITCH for 4 cycles, then hf_ready=1; hf_en never drops.
REQ-032 reset pulsed during WAKE cycle 3: next edge hf_en=0, clk_sel=0; with req still high, WAKE restarts and takes the full 8 cycles.
REQ-033 With HFOSC_STATS_EN defined, scenario REQ-029 SHALL yield hf_cycles=32; without the macro, hf_cycles=0.
REQ-034 WAKE_CYC=1, SETTLE_CYC=1, IDLE_CYC=1, single-cycle req: hf_en at 1, clk_sel at 2, hf_ready at 3 only, DRAIN at 4, OFF at 5.

Source files
------------

// File: rtl/hfosc_sched.sv
`default_nettype none
// ============================================================================
// Module   : hfosc_sched
// Purpose  : Sequences the high-frequency oscillator enable and the
//            glitch-free clock mux select on behalf of NREQ requesters.
//            Runs entirely in the low-frequency clock domain.
//            State flow: OFF -> WAKE -> SWITCH -> ON -> DRAIN -> OFF,
//            with DRAIN -> SWITCH when a request returns while draining.
// Ports    : clk        - low-frequency clock (only clock of the block)
//            reset      - synchronous, active-high reset
//            req        - per-requester level demand for the HF clock
//            hf_en      - oscillator enable
//            clk_sel    - mux select, 1 = high-frequency clock
//            hf_ready   - HF clock selected and stable
//            gnt        - req & hf_ready (combinational)
//            hf_cycles  - saturating count of cycles with hf_en high
// Config   : HFOSC_STATS_EN - when defined, hf_cycles counts; otherwise
//            hf_cycles is tied to 0 and the counter is not built.
// Revision : 1.0 - initial release
// ============================================================================
module hfosc_sched #(
  parameter int NREQ       = 4,
  parameter int WAKE_CYC   = 8,
  parameter int SETTLE_CYC = 4,
  parameter int IDLE_CYC   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic            hf_en,
  output logic            clk_sel,
  output logic            hf_ready,
  output logic [NREQ-1:0] gnt,
  output logic [15:0]     hf_cycles
);

  localparam logic [7:0] c_WAKE_LD   = 8'(WAKE_CYC - 1);
  localparam logic [7:0] c_SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] c_IDLE_LD   = 8'(IDLE_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_WAKE   = 3'd1,
    S_SWITCH = 3'd2,
    S_ON     = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] phase_q;
  logic [7:0] idle_q;
  logic       hf_en_q;
  logic       clk_sel_q;
  logic       hf_ready_q;
  logic       w_any_req;

  assign w_any_req = |req;

  // Outputs are registered together with the state so that each output
  // flop always holds the decode of the state it is entering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_OFF;
      phase_q    <= 8'd0;
      idle_q     <= 8'd0;
      hf_en_q    <= 1'b0;
      clk_sel_q  <= 1'b0;
      hf_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (w_any_req) begin
            state_q    <= S_WAKE;
            phase_q    <= c_WAKE_LD;
            hf_en_q    <= 1'b1;
            clk_sel_q  <= 1'b0;
            hf_ready_q <= 1'b0;
          end
        end
        // Request drop during WAKE/SWITCH does not abort: the sequence
        // always completes to ON and then idles out.
        S_WAKE: begin
          if (phase_q == 8'd0) begin
            state_q    <= S_SWITCH;
            phase_q    <= c_SETTLE_LD;
            clk_sel_q  <= 1'b1;
          end else begin
            phase_q    <= phase_q - 8'd1;
          end
        end
        S_SWITCH: begin
          if (phase_q == 8'd0) begin
            state_q    <= S_ON;
            idle_q     <= c_IDLE_LD;
            hf_ready_q <= 1'b1;
          end else begin
            phase_q    <= phase_q - 8'd1;
          end
        end
        S_ON: begin
          if (w_any_req) begin
            idle_q     <= c_IDLE_LD;
          end else if (idle_q == 8'd0) begin
            state_q    <= S_DRAIN;
            phase_q    <= c_SETTLE_LD;
            clk_sel_q  <= 1'b0;
            hf_ready_q <= 1'b0;
          end else begin
            idle_q     <= idle_q - 8'd1;
          end
        end
        // Oscillator stays enabled while the mux switches back; a request
        // seen in the exit cycle re-selects HF without a new WAKE.
        S_DRAIN: begin
          if (phase_q == 8'd0) begin
            if (w_any_req) begin
              state_q    <= S_SWITCH;
              phase_q    <= c_SETTLE_LD;
              clk_sel_q  <= 1'b1;
            end else begin
              state_q    <= S_OFF;
              hf_en_q    <= 1'b0;
            end
          end else begin
            phase_q    <= phase_q - 8'd1;
          end
        end
        default: begin
          state_q    <= S_OFF;
          phase_q    <= 8'd0;
          idle_q     <= 8'd0;
          hf_en_q    <= 1'b0;
          clk_sel_q  <= 1'b0;
          hf_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign hf_en    = hf_en_q;
  assign clk_sel  = clk_sel_q;
  assign hf_ready = hf_ready_q;
  assign gnt      = req & {NREQ{hf_ready_q}};

`ifdef HFOSC_STATS_EN
  logic [15:0] hf_cycles_q;
  logic [15:0] hf_cycles_d;

  // Saturate rather than wrap so a long-running count stays meaningful.
  always_comb begin
    hf_cycles_d = hf_cycles_q;
    if (hf_en_q && (hf_cycles_q != 16'hFFFF)) begin
      hf_cycles_d = hf_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hf_cycles_q <= 16'd0;
    end else begin
      hf_cycles_q <= hf_cycles_d;
    end
  end

  assign hf_cycles = hf_cycles_q;
`else
  assign hf_cycles = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hfosc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hfosc_sched
// Purpose  : Directed self-checking bench for hfosc_sched. One instance uses
//            the default parameters, a second uses WAKE/SETTLE/IDLE = 1.
//            Cycle n (n >= 1) is the cycle following the n-th clock edge
//            after the scenario starts; edge 0 samples the first request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hfosc_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req2;
  logic        hf_en, clk_sel, hf_ready;
  logic [3:0]  gnt;
  logic [15:0] hf_cycles;
  logic        hf_en2, clk_sel2, hf_ready2;
  logic [3:0]  gnt2;
  logic [15:0] hf_cycles2;

  int n_vec;
  int n_err;
  int cyc;

  logic [6:0]  obs;
  logic [6:0]  exp_v;
  logic [15:0] exp_cnt_pulse;
  logic [15:0] exp_cnt_min;

  hfosc_sched #(.NREQ(4), .WAKE_CYC(8), .SETTLE_CYC(4), .IDLE_CYC(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .hf_en     (hf_en),
    .clk_sel   (clk_sel),
    .hf_ready  (hf_ready),
    .gnt       (gnt),
    .hf_cycles (hf_cycles)
  );

  hfosc_sched #(.NREQ(4), .WAKE_CYC(1), .SETTLE_CYC(1), .IDLE_CYC(1)) u_dut_min (
    .clk       (clk),
    .reset     (reset),
    .req       (req2),
    .hf_en     (hf_en2),
    .clk_sel   (clk_sel2),
    .hf_ready  (hf_ready2),
    .gnt       (gnt2),
    .hf_cycles (hf_cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    req2  = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Reset state of both instances, with a request held during reset.
  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    req2  = 4'b1111;
    tick();
    tick();
    #1;
    n_vec++;
    obs = {hf_en, clk_sel, hf_ready, gnt};
    if (obs !== 7'b0) begin
      $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0);
      n_err++;
    end
    n_vec++;
    if (hf_cycles !== 16'd0) begin
      $display("FAIL reset_hf_cycles got=%0d exp=0", hf_cycles);
      n_err++;
    end
    n_vec++;
    obs = {hf_en2, clk_sel2, hf_ready2, gnt2};
    if (obs !== 7'b0) begin
      $display("FAIL reset_outputs_min got=%b exp=%b", obs, 7'b0);
      n_err++;
    end
    do_reset();
  endtask

  // Single-cycle pulse on req[0]; full sequence through timeout and drain.
  task automatic test_pulse();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    while (cyc <= 36) begin
      #1;
      exp_v[6]   = (cyc >= 1) && (cyc <= 32);
      exp_v[5]   = (cyc >= 9) && (cyc <= 28);
      exp_v[4]   = (cyc >= 13) && (cyc <= 28);
      exp_v[3:0] = 4'b0000;
      obs = {hf_en, clk_sel, hf_ready, gnt};
      n_vec++;
      if (obs !== exp_v) begin
        $display("FAIL pulse cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_err++;
      end
      if (cyc == 36) begin
        n_vec++;
        if (hf_cycles !== exp_cnt_pulse) begin
          $display("FAIL pulse_hf_cycles got=%0d exp=%0d", hf_cycles, exp_cnt_pulse);
          n_err++;
        end
      end
      tick();
    end
  endtask

  // req[2] held: stays in ON, only gnt[2] granted.
  task automatic test_hold();
    do_reset();
    req = 4'b0100;
    tick();
    while (cyc <= 60) begin
      #1;
      exp_v[6]   = 1'b1;
      exp_v[5]   = (cyc >= 9);
      exp_v[4]   = (cyc >= 13);
      exp_v[3:0] = (cyc >= 13) ? 4'b0100 : 4'b0000;
      obs = {hf_en, clk_sel, hf_ready, gnt};
      n_vec++;
      if (obs !== exp_v) begin
        $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_err++;
      end
      tick();
    end
  endtask

  // Request returns in the 2nd DRAIN cycle: drain completes, then SWITCH.
  task automatic test_redrain();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    while (cyc <= 44) begin
      if (cyc >= 30) req = 4'b0010;
      #1;
      exp_v[6]   = 1'b1;
      exp_v[5]   = ((cyc >= 9) && (cyc <= 28)) || (cyc >= 33);
      exp_v[4]   = ((cyc >= 13) && (cyc <= 28)) || (cyc >= 37);
      exp_v[3:0] = (cyc >= 37) ? 4'b0010 : 4'b0000;
      obs = {hf_en, clk_sel, hf_ready, gnt};
      n_vec++;
      if (obs !== exp_v) begin
        $display("FAIL redrain cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_err++;
      end
      tick();
    end
  endtask

  // Reset during WAKE cycle 3 with req held: WAKE restarts from scratch.
  task automatic test_reset_mid_wake();
    do_reset();
    req = 4'b0001;
    tick();
    while (cyc <= 20) begin
      reset = (cyc == 3);
      #1;
      exp_v[6]   = (cyc <= 3) || (cyc >= 5);
      exp_v[5]   = (cyc >= 13);
      exp_v[4]   = (cyc >= 17);
      exp_v[3:0] = (cyc >= 17) ? 4'b0001 : 4'b0000;
      obs = {hf_en, clk_sel, hf_ready, gnt};
      n_vec++;
      if (obs !== exp_v) begin
        $display("FAIL reset_mid_wake cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_err++;
      end
      tick();
    end
    reset = 1'b0;
  endtask

  // Minimum-parameter instance, single-cycle request.
  task automatic test_min_params();
    do_reset();
    req2 = 4'b1000;
    tick();
    req2 = 4'b0000;
    while (cyc <= 7) begin
      #1;
      exp_v[6]   = (cyc >= 1) && (cyc <= 4);
      exp_v[5]   = (cyc >= 2) && (cyc <= 3);
      exp_v[4]   = (cyc == 3);
      exp_v[3:0] = 4'b0000;
      obs = {hf_en2, clk_sel2, hf_ready2, gnt2};
      n_vec++;
      if (obs !== exp_v) begin
        $display("FAIL min_params cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
        n_err++;
      end
      if (cyc == 7) begin
        n_vec++;
        if (hf_cycles2 !== exp_cnt_min) begin
          $display("FAIL min_hf_cycles got=%0d exp=%0d", hf_cycles2, exp_cnt_min);
          n_err++;
        end
      end
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    reset = 1'b1;
    req   = 4'b0000;
    req2  = 4'b0000;
`ifdef HFOSC_STATS_EN
    exp_cnt_pulse = 16'd32;
    exp_cnt_min   = 16'd4;
`else
    exp_cnt_pulse = 16'd0;
    exp_cnt_min   = 16'd0;
`endif
    test_reset();
    test_pulse();
    test_hold();
    test_redrain();
    test_reset_mid_wake();
    test_min_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
